// File: rtl/muldiv_if.sv
// Handshake and operand bus between the execute stage and the mul/div sequencer.
interface muldiv_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  modport master (output Start, Op, SrcA, SrcB, Flush, input Busy, Done, Result);
  modport slave  (input Start, Op, SrcA, SrcB, Flush, output Busy, Done, Result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer: 32 shift-add or restoring-subtract
// iterations on operand magnitudes, sign fix-up and special cases at completion.
module muldiv_unit (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] res_q, res_d;

  // Operation context captured at acceptance
  logic [2:0]  op_q;
  logic        neg_a_q, neg_b_q;
  logic [31:0] m_q;          // multiplicand (mul) or divisor magnitude (div)
  logic        spec_q;
  logic [31:0] spec_val_q;

  // Shared iteration register pair: {acc, multiplier} or {remainder, quotient}
  logic [31:0] hi_q, lo_q, hi_d, lo_d;

  logic        accept, finish;
  logic        sgn_a, sgn_b, spec_d;
  logic [31:0] amag, bmag, spec_val_d;
  logic [32:0] sum_mul;
  logic [32:0] shl_rem;
  logic [33:0] diff;
  logic [63:0] prod;

  function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  assign accept = (state_q != S_CALC) && bus.Start && !bus.Flush;
  assign finish = (state_q == S_CALC) && (state_d == S_DONE);

  // Operand sign handling and special-case detection at capture
  always_comb begin
    sgn_a = ((bus.Op == 3'b001) || (bus.Op == 3'b010) ||
             (bus.Op == 3'b100) || (bus.Op == 3'b110)) && bus.SrcA[31];
    sgn_b = ((bus.Op == 3'b001) || (bus.Op == 3'b100) || (bus.Op == 3'b110)) && bus.SrcB[31];
    amag  = neg_if32(bus.SrcA, sgn_a);
    bmag  = neg_if32(bus.SrcB, sgn_b);
    spec_d     = 1'b0;
    spec_val_d = 32'd0;
    if (bus.Op[2]) begin
      if (bus.SrcB == 32'd0) begin
        spec_d     = 1'b1;
        spec_val_d = bus.Op[1] ? bus.SrcA : 32'hFFFF_FFFF;
      end else if (!bus.Op[0] && (bus.SrcA == 32'h8000_0000) && (bus.SrcB == 32'hFFFF_FFFF)) begin
        spec_d     = 1'b1;
        spec_val_d = bus.Op[1] ? 32'd0 : 32'h8000_0000;
      end
    end
  end

  // One multiply or divide iteration, plus the final signed result
  always_comb begin
    sum_mul = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
    shl_rem = {hi_q, lo_q[31]};
    diff    = {1'b0, shl_rem} - {2'b00, m_q};
    if (!op_q[2]) begin
      hi_d = sum_mul[32:1];
      lo_d = {sum_mul[0], lo_q[31:1]};
    end else if (!diff[33]) begin
      hi_d = diff[31:0];
      lo_d = {lo_q[30:0], 1'b1};
    end else begin
      hi_d = shl_rem[31:0];
      lo_d = {lo_q[30:0], 1'b0};
    end
    prod = neg_if64({hi_d, lo_d}, neg_a_q ^ neg_b_q);
    if (spec_q)           res_d = spec_val_q;
    else if (!op_q[2])    res_d = (op_q == 3'b000) ? prod[31:0] : prod[63:32];
    else if (op_q[1])     res_d = neg_if32(hi_d, neg_a_q);
    else                  res_d = neg_if32(lo_d, neg_a_q ^ neg_b_q);
  end

  // Next-state logic; Flush overrides everything but reset
  always_comb begin
    state_d = state_q;
    if (bus.Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.Start) state_d = S_CALC;
        S_CALC:  if (cnt_q == 5'd31) state_d = S_DONE;
        S_DONE:  state_d = bus.Start ? S_CALC : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state, iteration counter and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept)                  cnt_q <= 5'd0;
      else if (state_q == S_CALC)  cnt_q <= cnt_q + 5'd1;
      if (finish)                  res_q <= res_d;
    end
  end

  // Datapath: capture on accept, iterate while calculating
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= bus.Op;
      neg_a_q    <= sgn_a;
      neg_b_q    <= sgn_b;
      m_q        <= bus.Op[2] ? bmag : amag;
      lo_q       <= bus.Op[2] ? amag : bmag;
      hi_q       <= 32'd0;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
    end else if (state_q == S_CALC) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.Busy   = (state_q == S_CALC);
  assign bus.Done   = (state_q == S_DONE);
  assign bus.Result = res_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer for the RV32M extension, sitting beside the ALU in the execute stage. It accepts one operation per handshake, runs a 32-iteration shift-add (multiply) or restoring-subtract (divide) loop on captured operands, and returns a registered 32-bit result with a one-cycle Done pulse. The hazard logic holds the pipeline while Busy is high and can abort an in-flight operation with Flush.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Start  in  1  request; sampled only in IDLE or DONE state
- Op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  32  rs1 operand (dividend / multiplicand)
- SrcB  in  32  rs2 operand (divisor / multiplier)
- Flush  in  1  abort the current operation; no Done is produced
- Busy  out  1  high while in CALC state
- Done  out  1  one-cycle pulse; Result valid in the same cycle
- Result  out  32  registered result, held until the next accepted Start

## Operation
- States: IDLE, CALC, DONE. Reset puts the block in IDLE with Busy=0, Done=0, Result=0, and clears the iteration counter.
- IDLE/DONE with Start=1 and Flush=0: capture Op, SrcA and SrcB. Record the operand signs: signed for MULH and DIV/REM on both operands, and signed for the A operand only on MULHSU. Convert the operands to magnitudes, clear the counter, and go to CALC. In DONE, a Start is accepted back-to-back.
- IDLE with Start=0: stay in IDLE. DONE with Start=0: go to IDLE.
- CALC: perform one iteration per cycle and increment the 5-bit counter. After the iteration with counter=31, go to DONE and register Result.
- Start during CALC is ignored. Operands may change after acceptance without effect.
- Multiply: 64-bit unsigned magnitude product, negated if the recorded signs differ.
  - MUL returns bits [31:0].
  - MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring division on magnitudes. The quotient is negated if the signs differ. The remainder takes the dividend's sign.
- Special cases are detected at capture and forced into Result at DONE. Latency is unchanged.
  - Divisor=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give SrcA.
  - DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Flush=1 in any state: go to IDLE on the next edge with Busy=0 and Done=0. Result keeps its previous value. Flush takes priority over a simultaneous Start, which is not accepted.
- reset takes priority over Flush and Start. Asserting reset mid-operation returns all outputs to their reset values on the next edge.

## Timing
- Start is sampled at edge E0. Busy is high from E0 through E32, which is 32 cycles. Done=1 and Result is valid from E32 to E33.
- Latency from Start to Done is 33 cycles. A Start in the Done cycle gives Busy again after the next edge, so throughput is one operation per 33 cycles.
- Busy and Done are never high in the same cycle.
- Result updates only on the CALC-to-DONE transition and on reset.

## Test plan
- MUL SrcA=7, SrcB=0xFFFFFFFD -> Done exactly 33 cycles after Start with Result=0xFFFFFFEB. Busy is high for exactly 32 cycles.
- High-word multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each still 33 cycles:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Flush after 10 CALC cycles -> Busy=0 on the next cycle, no Done, Result unchanged. A Start in the following cycle is accepted and completes normally. Flush and Start together in IDLE -> not accepted.
- Start pulses during CALC are ignored and SrcA/SrcB changes after acceptance do not affect the result. Start in the Done cycle begins a second operation with no idle gap. reset at CALC cycle 20 -> IDLE, Busy=0, Done=0, Result=0.
